// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3, error and state codes
// for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  function automatic logic f3_legal(
    input logic       st,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !st;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication
// and load lane extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  function automatic logic [3:0] gen_be(
    input logic [2:0] f,
    input logic [1:0] o
  );
    logic [3:0] b;
    case (f[1:0])
      2'b00:   b = 4'b0001 << o;
      2'b01:   b = 4'b0011 << o;
      default: b = 4'b1111;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] rep_store(
    input logic [2:0]  f,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (f[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ext_load(
    input logic [2:0]  f,
    input logic [1:0]  o,
    input logic [31:0] d
  );
    logic [31:0] s;
    logic [31:0] r;
    s = d >> {o, 3'b000};
    case (f)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_BU:   r = {24'd0, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_HU:   r = {16'd0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign be        = gen_be(f3, off);
  assign wdata_rep = rep_store(f3, wdata);
  assign ld_data   = ext_load(ld_f3, ld_off, mem_rdata);

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store FSM with valid/ack memory
// handshake, error reporting and timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_c;
  logic [31:0] wrep_c;
  logic [31:0] ld_c;
  logic        legal_c;
  logic        mis_c;

  lsu_align u_align (
    .f3        (funct3),
    .off       (addr[1:0]),
    .wdata     (wdata),
    .ld_f3     (f3_q),
    .ld_off    (off_q),
    .mem_rdata (mem_rdata),
    .be        (be_c),
    .wdata_rep (wrep_c),
    .ld_data   (ld_c)
  );

  assign legal_c = f3_legal(is_store, funct3);
  assign mis_c   = misaligned(funct3, addr[1:0]);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata     <= '0;
      err       <= ERR_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            st_q  <= is_store;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            cnt   <= 8'd0;
            rdata <= '0;
            if (!legal_c) begin
              err   <= ERR_ILLEGAL;
              state <= S_RESP;
            end else if (mis_c) begin
              err   <= ERR_MISALIGN;
              state <= S_RESP;
            end else begin
              err       <= ERR_OK;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wrep_c;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + 8'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!st_q) rdata <= ld_c;
            state <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= ERR_TIMEOUT;
            state   <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random accesses against
// a byte-level reference model of the LSU.
module tb_lsu_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [1:0]  err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  int exp_dones = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always @(posedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // dly: REQ cycle index carrying the ack; outside 0..TMO-1 means no ack
  task automatic run_op(
    input bit          st,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          dly,
    input bit          poke
  );
    bit          legal, acked;
    int          n;
    logic [1:0]  e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, lane, mask;
    legal = st ? (f3 <= 3'd2)
               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    acked = (dly >= 0) && (dly < TMO);
    if (!legal) e_err = 2'b11;
    else if ((a % n) != 0) e_err = 2'b01;
    else if (!acked) e_err = 2'b10;
    else e_err = 2'b00;
    e_be = 4'(((1 << n) - 1) << a[1:0]);
    for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = wd[8*(k % n) +: 8];
    e_rd = 32'd0;
    if (!st && e_err == 2'b00) begin
      lane = rd >> (8 * a[1:0]);
      if (n == 4) e_rd = lane;
      else begin
        mask = (32'd1 << (8 * n)) - 32'd1;
        e_rd = lane & mask;
        if (!f3[2] && e_rd[8*n-1]) e_rd = e_rd | ~mask;
      end
    end

    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    start = 1'b1; is_store = st; funct3 = f3;
    addr = a; wdata = wd;
    mem_ack = 1'($urandom % 2);
    mem_rdata = $urandom;
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0;
    exp_dones++;
    if (e_err == 2'b11 || e_err == 2'b01) begin
      chk("err_done", 32'(done), 32'd1);
      chk("err_code", 32'(err), 32'(e_err));
      chk("err_rdata", rdata, 32'd0);
      chk("err_noreq", 32'(mem_req), 32'd0);
      return;
    end
    for (int k = 0; k < 16; k++) begin
      chk("req", 32'(mem_req), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("maddr", mem_addr, {a[31:2], 2'b00});
      chk("mwe", 32'(mem_we), 32'(st));
      if (k == 0) begin
        chk("mbe", 32'(mem_be), 32'(e_be));
        if (st) chk("mwdata", mem_wdata, e_wd);
        if (poke) begin
          start = 1'b1; is_store = ~st;
          funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        end
      end
      if (k == dly) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; mem_ack = 1'b0;
      if (k == dly) break;
      if (k == TMO - 1) break;
      if (k == 15) chk("req_bound", 32'd1, 32'd0);
    end
    chk("resp_done", 32'(done), 32'd1);
    chk("resp_err", 32'(err), 32'(e_err));
    chk("resp_rdata", rdata, e_rd);
    chk("resp_noreq", 32'(mem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    run_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    run_op(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    run_op(0, 3'b000, 32'h1, 32'h0, 32'h80F07F11, 0, 0);
    run_op(0, 3'b000, 32'h3, 32'h0, 32'h80F07F11, 1, 0);
    run_op(0, 3'b100, 32'h3, 32'h0, 32'h80F07F11, 2, 1);
    run_op(0, 3'b001, 32'h2, 32'h0, 32'h80F07F11, 0, 0);
    run_op(0, 3'b101, 32'h2, 32'h0, 32'h80F07F11, 3, 0);
    run_op(0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
    run_op(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    run_op(1, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 0);
    run_op(0, 3'b010, 32'h200, 32'h0, 32'h12345678, -1, 1);
    run_op(1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      run_op(1'($urandom % 2), 3'($urandom), $urandom, $urandom,
             $urandom, int'($urandom % 7) - 1, ($urandom % 4) == 0);
    end

    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010;
    addr = 32'h300; wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rq_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rq_req_drop", 32'(mem_req), 32'd0);
    chk("rq_busy", 32'(busy), 32'd0);
    chk("rq_done", 32'(done), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rq_no_done", 32'(done), 32'd0);
    end
    run_op(0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 0, 0);

    @(posedge clk); #1;
    chk("done_count", 32'(done_seen), 32'(exp_dones));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
